// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the BCD digit serializer / packer pair: receiver FSM
// states, nibble width, legal digit range and the default word length.
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  localparam int          DIGIT_W        = 4;
  localparam logic [3:0]  BIN_DIGIT_HI   = 4'h0;
  localparam logic [3:0]  ASCII_DIGIT_HI = 4'h3;
  localparam logic [3:0]  MAX_DIGIT      = 4'd9;
  localparam int          DEFAULT_DIGITS = 11;

endpackage

// File: rtl/bcd_digit_packer_if.sv
// -----------------------------------------------------------------------------
// bcd_digit_packer_if
// Digit-in / word-out bundle of the BCD digit packer.
//   din, din_valid, din_sof, din_ready : digit stream (valid/ready)
//   num, num_valid, num_ready          : packed BCD word (valid/ready)
//   err                                : one-cycle illegal-code pulse
//   digit_cnt                          : digits held in the current word
// modport slave  : the packer side
// modport master : the digit source / word consumer side
// -----------------------------------------------------------------------------
interface bcd_digit_packer_if #(
  parameter int DIGITS = 11
) ();
  localparam int NUM_W = 4 * DIGITS;

  logic [7:0]       din;
  logic             din_valid;
  logic             din_sof;
  logic             din_ready;
  logic [NUM_W-1:0] num;
  logic             num_valid;
  logic             num_ready;
  logic             err;
  logic [3:0]       digit_cnt;

  modport slave (
    input  din, din_valid, din_sof, num_ready,
    output din_ready, num, num_valid, err, digit_cnt
  );

  modport master (
    output din, din_valid, din_sof, num_ready,
    input  din_ready, num, num_valid, err, digit_cnt
  );

endinterface

// File: rtl/bcd_digit_check.sv
// -----------------------------------------------------------------------------
// bcd_digit_check
// Combinational decode of one digit code into a BCD nibble plus a legality
// flag. Binary mode accepts 8'h00..8'h09, ASCII mode accepts 8'h30..8'h39.
// Ports:
//   i_code   : 8-bit digit code
//   o_legal  : code is a decimal digit in the selected encoding
//   o_nibble : low nibble of the code (meaningful only when o_legal)
// -----------------------------------------------------------------------------
module bcd_digit_check
  import bcd_pkg::*;
#(
  parameter bit ASCII_IN = 1'b0
) (
  input  logic [7:0]         i_code,
  output logic               o_legal,
  output logic [DIGIT_W-1:0] o_nibble
);

  localparam logic [3:0] CODE_HI = ASCII_IN ? ASCII_DIGIT_HI : BIN_DIGIT_HI;

  assign o_nibble = i_code[3:0];
  assign o_legal  = (i_code[7:4] == CODE_HI) && (i_code[3:0] <= MAX_DIGIT);

endmodule

// File: rtl/bcd_digit_packer.sv
// -----------------------------------------------------------------------------
// bcd_digit_packer
// Collects a least-significant-first stream of digit codes into a packed BCD
// word of DIGITS nibbles (digit k in num[4k+3:4k]) and offers it on a
// valid/ready output. Illegal codes raise a one-cycle err pulse and drop the
// partial word; din_sof restarts the word at the flagged digit.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bcd_digit_packer_if.slave (digit stream, word output, err, count)
// -----------------------------------------------------------------------------
module bcd_digit_packer
  import bcd_pkg::*;
#(
  parameter int DIGITS   = DEFAULT_DIGITS,
  parameter bit ASCII_IN = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_digit_packer_if.slave  bus
);

  localparam int         NUM_W    = DIGIT_W * DIGITS;
  localparam logic [3:0] CNT_FULL = 4'(DIGITS);

  state_t             r_state, w_state_nxt;
  logic [NUM_W-1:0]   r_shreg, w_shreg_nxt;
  logic [NUM_W-1:0]   r_num, w_num_nxt;
  logic               r_num_valid, w_num_valid_nxt;
  logic               r_err, w_err_nxt;
  logic               r_ready, w_ready_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;

  logic               w_legal;
  logic [DIGIT_W-1:0] w_nibble;
  logic               w_accept;
  logic               w_fresh;
  logic [NUM_W-1:0]   w_shift_word;
  logic [NUM_W-1:0]   w_fresh_word;

  bcd_digit_check #(
    .ASCII_IN (ASCII_IN)
  ) u_check (
    .i_code   (bus.din),
    .o_legal  (w_legal),
    .o_nibble (w_nibble)
  );

  assign w_accept = bus.din_valid & r_ready;

  // A word restarts on sof, and also whenever nothing is held, so stale
  // nibbles from the previous word never leak into the new one.
  assign w_fresh = bus.din_sof | (r_state == IDLE);

  // New digits enter at the top; after DIGITS shifts the first lands in [3:0].
  if (DIGITS == 1) begin : g_one_digit
    assign w_shift_word = w_nibble;
    assign w_fresh_word = w_nibble;
  end else begin : g_multi_digit
    assign w_shift_word = {w_nibble, r_shreg[NUM_W-1:DIGIT_W]};
    assign w_fresh_word = {w_nibble, {(NUM_W-DIGIT_W){1'b0}}};
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_shreg_nxt     = r_shreg;
    w_num_nxt       = r_num;
    w_num_valid_nxt = r_num_valid;
    w_cnt_nxt       = r_cnt;
    w_err_nxt       = 1'b0;

    case (r_state)
      IDLE, COLLECT: begin
        if (w_accept) begin
          if (!w_legal) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = 4'd0;
            w_shreg_nxt = '0;
          end else begin
            w_cnt_nxt   = w_fresh ? 4'd1 : (r_cnt + 4'd1);
            w_shreg_nxt = w_fresh ? w_fresh_word : w_shift_word;
            if (w_cnt_nxt == CNT_FULL) begin
              w_state_nxt     = OUTPUT;
              w_num_nxt       = w_shreg_nxt;
              w_num_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = COLLECT;
            end
          end
        end
      end
      OUTPUT: begin
        if (bus.num_ready) begin
          w_state_nxt     = IDLE;
          w_num_valid_nxt = 1'b0;
          w_cnt_nxt       = 4'd0;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_num_valid_nxt = 1'b0;
        w_cnt_nxt       = 4'd0;
      end
    endcase

    // Ready is registered alongside the state so it is low during reset and
    // drops in the same cycle the word appears.
    w_ready_nxt = (w_state_nxt != OUTPUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_num       <= '0;
      r_num_valid <= 1'b0;
      r_err       <= 1'b0;
      r_ready     <= 1'b0;
      r_cnt       <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_shreg_nxt;
      r_num       <= w_num_nxt;
      r_num_valid <= w_num_valid_nxt;
      r_err       <= w_err_nxt;
      r_ready     <= w_ready_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign bus.din_ready = r_ready;
  assign bus.num       = r_num;
  assign bus.num_valid = r_num_valid;
  assign bus.err       = r_err;
  assign bus.digit_cnt = r_cnt;

endmodule

// File: tb/tb_bcd_digit_packer.sv
// -----------------------------------------------------------------------------
// tb_bcd_digit_packer
// Two packers (binary and ASCII digit codes, 11 digits each) driven with
// directed digit streams; expected counts, flags and words are hand-computed.
// -----------------------------------------------------------------------------
module tb_bcd_digit_packer;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  bcd_digit_packer_if #(.DIGITS(11)) if0 ();
  bcd_digit_packer_if #(.DIGITS(11)) if1 ();

  bcd_digit_packer #(.DIGITS(11), .ASCII_IN(1'b0)) u_dut_bin (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  bcd_digit_packer #(.DIGITS(11), .ASCII_IN(1'b1)) u_dut_asc (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [7:0]  code;
    logic        sof;
    logic [3:0]  cnt;
    logic        err;
    logic        nv;
    logic        rdy;
    logic        chk_num;
    logic [43:0] num;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic vld, input logic [7:0] code, input logic sof,
                              input logic [3:0] cnt, input logic err, input logic nv,
                              input logic rdy, input logic chk_num, input logic [43:0] num);
    vec_t v;
    v.vld = vld; v.code = code; v.sof = sof; v.cnt = cnt; v.err = err;
    v.nv = nv; v.rdy = rdy; v.chk_num = chk_num; v.num = num;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic [7:0] c, input logic s);
    if (p == 0) begin
      if0.din_valid = v; if0.din = c; if0.din_sof = s;
    end else begin
      if1.din_valid = v; if1.din = c; if1.din_sof = s;
    end
  endtask

  // Present one code for one clock edge, then sample 1 time unit later.
  task automatic send(input int p, input logic [7:0] c, input logic s);
    drive(p, 1'b1, c, s);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int p);
    drive(p, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    if0.num_ready = 1'b1;
    if1.num_ready = 1'b1;

    // Vector table for the binary-code packer (consumer always ready).
    for (int i = 0; i < 11; i++)
      add(1'b1, 8'((i + 1) % 10), (i == 0), 4'(i + 1), 1'b0, (i == 10), (i != 10),
          (i == 10), 44'h10987654321);
    add(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 44'h10987654321);
    for (int i = 0; i < 4; i++)
      add(1'b1, 8'(i + 2), 1'b0, 4'(i + 1), 1'b0, 1'b0, 1'b1, 1'b0, 44'h0);
    add(1'b1, 8'h0A, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 44'h0);
    for (int i = 0; i < 11; i++)
      add(1'b1, 8'h07, 1'b0, 4'(i + 1), 1'b0, (i == 10), (i != 10), (i == 10),
          44'h77777777777);
    add(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 44'h77777777777);
    for (int i = 0; i < 5; i++)
      add(1'b1, 8'h05, (i == 0), 4'(i + 1), 1'b0, 1'b0, 1'b1, 1'b0, 44'h0);
    add(1'b1, 8'h03, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 44'h0);
    for (int i = 0; i < 10; i++)
      add(1'b1, 8'h00, 1'b0, 4'(i + 2), 1'b0, (i == 9), (i != 9), (i == 9),
          44'h00000000003);
    add(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 44'h00000000003);
    add(1'b1, 8'h04, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 44'h0);
    add(1'b1, 8'h04, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 44'h0);
    add(1'b1, 8'h34, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 44'h0);
    add(1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 44'h00000000003);

    // Reset state, held across several edges.
    repeat (3) @(negedge clk);
    chk("rst_rdy0", 64'(if0.din_ready), 64'd0);
    chk("rst_nv0",  64'(if0.num_valid), 64'd0);
    chk("rst_cnt0", 64'(if0.digit_cnt), 64'd0);
    chk("rst_err0", 64'(if0.err),       64'd0);
    chk("rst_num0", 64'(if0.num),       64'd0);
    chk("rst_rdy1", 64'(if1.din_ready), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_rdy0", 64'(if0.din_ready), 64'd1);
    chk("rel_rdy1", 64'(if1.din_ready), 64'd1);

    // Table-driven streams.
    foreach (vq[k]) begin
      drive(0, vq[k].vld, vq[k].code, vq[k].sof);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cnt", k), 64'(if0.digit_cnt), 64'(vq[k].cnt));
      chk($sformatf("v%0d_err", k), 64'(if0.err),       64'(vq[k].err));
      chk($sformatf("v%0d_nv",  k), 64'(if0.num_valid), 64'(vq[k].nv));
      chk($sformatf("v%0d_rdy", k), 64'(if0.din_ready), 64'(vq[k].rdy));
      if (vq[k].chk_num)
        chk($sformatf("v%0d_num", k), 64'(if0.num), 64'(vq[k].num));
    end

    // Backpressure: word held while the consumer stalls, extra digits ignored.
    if0.num_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(0, 8'((i + 1) % 10), (i == 0));
    chk("bp_nv",  64'(if0.num_valid), 64'd1);
    chk("bp_num", 64'(if0.num), 64'h10987654321);
    for (int i = 0; i < 5; i++) begin
      send(0, 8'h05, 1'b0);
      chk("bp_hold_nv",  64'(if0.num_valid), 64'd1);
      chk("bp_hold_rdy", 64'(if0.din_ready), 64'd0);
      chk("bp_hold_num", 64'(if0.num), 64'h10987654321);
      chk("bp_hold_cnt", 64'(if0.digit_cnt), 64'd11);
      chk("bp_hold_err", 64'(if0.err), 64'd0);
    end
    if0.num_ready = 1'b1;
    idle(0);
    chk("bp_rel_nv",  64'(if0.num_valid), 64'd0);
    chk("bp_rel_rdy", 64'(if0.din_ready), 64'd1);
    chk("bp_rel_cnt", 64'(if0.digit_cnt), 64'd0);
    chk("bp_rel_num", 64'(if0.num), 64'h10987654321);

    // ASCII-code packer.
    for (int i = 0; i < 11; i++) send(1, 8'h39, (i == 0));
    chk("asc_nv",  64'(if1.num_valid), 64'd1);
    chk("asc_num", 64'(if1.num), 64'h99999999999);
    idle(1);
    chk("asc_rel_nv", 64'(if1.num_valid), 64'd0);
    send(1, 8'h09, 1'b0);
    chk("asc_bin_err", 64'(if1.err), 64'd1);
    chk("asc_bin_cnt", 64'(if1.digit_cnt), 64'd0);
    idle(1);
    chk("asc_err_end", 64'(if1.err), 64'd0);

    // Asynchronous reset mid-word.
    for (int i = 0; i < 6; i++) send(0, 8'h02, (i == 0));
    chk("ar_cnt6", 64'(if0.digit_cnt), 64'd6);
    drive(0, 1'b0, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mid_cnt", 64'(if0.digit_cnt), 64'd0);
    chk("ar_mid_nv",  64'(if0.num_valid), 64'd0);
    chk("ar_mid_err", 64'(if0.err), 64'd0);
    chk("ar_mid_num", 64'(if0.num), 64'd0);
    chk("ar_mid_rdy", 64'(if0.din_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_rel_rdy", 64'(if0.din_ready), 64'd1);

    // Asynchronous reset while a word is waiting.
    if0.num_ready = 1'b0;
    for (int i = 0; i < 11; i++) send(0, 8'h04, 1'b0);
    chk("ar_out_nv",  64'(if0.num_valid), 64'd1);
    chk("ar_out_num", 64'(if0.num), 64'h44444444444);
    drive(0, 1'b0, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_nv0",  64'(if0.num_valid), 64'd0);
    chk("ar_out_num0", 64'(if0.num), 64'd0);
    chk("ar_out_cnt0", 64'(if0.digit_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    if0.num_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) send(0, 8'((i + 1) % 10), (i == 0));
    chk("ar_clean_nv",  64'(if0.num_valid), 64'd1);
    chk("ar_clean_num", 64'(if0.num), 64'h10987654321);
    idle(0);
    chk("ar_clean_done", 64'(if0.num_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
